nvram_access_arb: RTL and testbench

// - Shares one 8Kx8 async NVRAM (nCE/nOE/nWE, 13-bit addr) between two requesters:
//   A = instrument-side bus bridge, B = SPI programming front end.
// - Two-way round-robin arbiter plus a bus-cycle sequencer with parameterised setup/strobe/hold.
// - Sits between the requesters and the top-level DQ tristate; this block never drives inout pins.

---
 rtl/nvram_access_arb_pkg.sv | 31 +++
 rtl/nvram_rr_arb.sv | 43 ++++
 rtl/nvram_access_arb.sv | 267 ++++++++++++++++++++++++++
 tb/tb_nvram_access_arb.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nvram_access_arb_pkg.sv
// Shared definitions for the NVRAM access arbiter: default geometry and
// bus-cycle timing, sequencer state encoding and a small helper used to
// size the shared phase counter.
package nvram_access_arb_pkg;

   localparam int DEF_ADDR_W    = 13;
   localparam int DEF_DATA_W    = 8;
   localparam int DEF_SETUP_CYC = 1;
   localparam int DEF_PULSE_CYC = 3;
   localparam int DEF_HOLD_CYC  = 1;

   // The readback states only become reachable when the write-verify
   // feature is compiled in; the encoding stays the same either way.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETUP   = 3'd1,
      ST_STROBE  = 3'd2,
      ST_HOLD    = 3'd3,
      ST_DONE    = 3'd4,
      ST_VSETUP  = 3'd5,
      ST_VSTROBE = 3'd6,
      ST_VHOLD   = 3'd7
   } seqState_t;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/nvram_rr_arb.sv
// Two-way round-robin arbiter. Bit 0 is requester A, bit 1 is requester B.
// With both requesting, the one not served last wins; the pointer moves on
// every grant so a lone requester also hands priority to the other side.
module nvram_rr_arb (
   input  logic       clk_i,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       grantEn_i,
   output logic [1:0] gnt_o
);

   logic ptr_q;
   logic ptr_d;

   // Grant decode: one-hot, only while the sequencer can accept a cycle
   always_comb begin
      gnt_o = 2'b00;
      ptr_d = ptr_q;
      if (grantEn_i) begin
         case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
         endcase
      end
      if (gnt_o[0]) begin
         ptr_d = 1'b1;
      end else if (gnt_o[1]) begin
         ptr_d = 1'b0;
      end
   end

   // Pointer register: 0 favours A, which is where reset leaves it
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/nvram_access_arb.sv
// Shares one async NVRAM between requester A (bus bridge) and requester B
// (SPI programmer). A round-robin grant starts a SETUP/STROBE/HOLD/DONE bus
// cycle; all strobes and bus outputs are registered.
// Optional feature macro NVRAM_VERIFY_EN: every write is followed by a
// readback phase whose mismatch sets the sticky vfy_fail flag.
module nvram_access_arb
   import nvram_access_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int PULSE_CYC = DEF_PULSE_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic              clk_i,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_wr,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_wr,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dq_o,
   output logic              mem_dq_oe,
   input  logic [DATA_W-1:0] mem_dq_i,
   output logic              nce,
   output logic              noe,
   output logic              nwe,
   output logic              busy
`ifdef NVRAM_VERIFY_EN
   ,
   output logic              vfy_fail,
   input  logic              vfy_clr
`endif
);

   localparam int MAX_CYC = maxOf3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

   seqState_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               selB_q, selB_d;
   logic               wr_q, wr_d;
   logic [ADDR_W-1:0]  memAddr_q, memAddr_d;
   logic [DATA_W-1:0]  memDqO_q, memDqO_d;
   logic               memDqOe_q, memDqOe_d;
   logic               nce_q, nce_d;
   logic               noe_q, noe_d;
   logic               nwe_q, nwe_d;
   logic               aAck_q, aAck_d;
   logic               bAck_q, bAck_d;
   logic [DATA_W-1:0]  aRdata_q, aRdata_d;
   logic [DATA_W-1:0]  bRdata_q, bRdata_d;
   logic [1:0]         gnt;
   logic               cntDone;
   logic               inCycle;

   assign cntDone = (cnt_q == '0);

   nvram_rr_arb uArb (
      .clk_i     (clk_i),
      .rst_n     (rst_n),
      .req_i     ({b_req, a_req}),
      .grantEn_i (state_q == ST_IDLE),
      .gnt_o     (gnt)
   );

   // Sequencer: latch the granted request in IDLE, then step through the
   // timed phases, reloading the single down-counter on each phase entry
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      selB_d    = selB_q;
      wr_d      = wr_q;
      memAddr_d = memAddr_q;
      memDqO_d  = memDqO_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt != 2'b00) begin
               selB_d    = gnt[1];
               wr_d      = gnt[1] ? b_wr : a_wr;
               memAddr_d = gnt[1] ? b_addr : a_addr;
               memDqO_d  = gnt[1] ? b_wdata : a_wdata;
               state_d   = ST_SETUP;
               cnt_d     = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cntDone) begin
               state_d = ST_STROBE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_STROBE: begin
            if (cntDone) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_HOLD: begin
            if (cntDone) begin
`ifdef NVRAM_VERIFY_EN
               if (wr_q) begin
                  state_d = ST_VSETUP;
                  cnt_d   = SETUP_LD;
               end else begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end
`else
               state_d = ST_DONE;
               cnt_d   = '0;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef NVRAM_VERIFY_EN
         ST_VSETUP: begin
            if (cntDone) begin
               state_d = ST_VSTROBE;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_VSTROBE: begin
            if (cntDone) begin
               state_d = ST_VHOLD;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_VHOLD: begin
            if (cntDone) begin
               state_d = ST_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`endif
         ST_DONE: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Bus outputs are decoded from the next state so they appear registered
   // from the edge that enters each phase; read data is taken on the edge
   // that leaves STROBE while noe is still low
   always_comb begin
      inCycle   = state_d inside {ST_SETUP, ST_STROBE, ST_HOLD,
                                  ST_VSETUP, ST_VSTROBE, ST_VHOLD};
      nce_d     = !inCycle;
      noe_d     = !(((state_d == ST_STROBE) && !wr_d) || (state_d == ST_VSTROBE));
      nwe_d     = !((state_d == ST_STROBE) && wr_d);
      memDqOe_d = wr_d && (state_d inside {ST_SETUP, ST_STROBE, ST_HOLD});
      aAck_d    = (state_d == ST_DONE) && !selB_d;
      bAck_d    = (state_d == ST_DONE) && selB_d;
      aRdata_d  = aRdata_q;
      bRdata_d  = bRdata_q;
      if ((state_q == ST_STROBE) && cntDone && !wr_q) begin
         if (selB_q) begin
            bRdata_d = mem_dq_i;
         end else begin
            aRdata_d = mem_dq_i;
         end
      end
   end

   // State and datapath registers; reset drops any cycle in flight at once
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         selB_q    <= 1'b0;
         wr_q      <= 1'b0;
         memAddr_q <= '1;
         memDqO_q  <= '0;
         memDqOe_q <= 1'b0;
         nce_q     <= 1'b1;
         noe_q     <= 1'b1;
         nwe_q     <= 1'b1;
         aAck_q    <= 1'b0;
         bAck_q    <= 1'b0;
         aRdata_q  <= '0;
         bRdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         selB_q    <= selB_d;
         wr_q      <= wr_d;
         memAddr_q <= memAddr_d;
         memDqO_q  <= memDqO_d;
         memDqOe_q <= memDqOe_d;
         nce_q     <= nce_d;
         noe_q     <= noe_d;
         nwe_q     <= nwe_d;
         aAck_q    <= aAck_d;
         bAck_q    <= bAck_d;
         aRdata_q  <= aRdata_d;
         bRdata_q  <= bRdata_d;
      end
   end

`ifdef NVRAM_VERIFY_EN
   logic vfyFail_q, vfyFail_d;
   logic vfyHit;

   // Readback compare against the data still held on mem_dq_o; a mismatch
   // outranks a simultaneous clear so no failure is ever lost
   always_comb begin
      vfyHit    = (state_q == ST_VSTROBE) && cntDone && (mem_dq_i != memDqO_q);
      vfyFail_d = vfyFail_q;
      if (vfyHit) begin
         vfyFail_d = 1'b1;
      end else if (vfy_clr) begin
         vfyFail_d = 1'b0;
      end
   end

   // Sticky verify-failure flag
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         vfyFail_q <= 1'b0;
      end else begin
         vfyFail_q <= vfyFail_d;
      end
   end

   assign vfy_fail = vfyFail_q;
`endif

   assign mem_addr  = memAddr_q;
   assign mem_dq_o  = memDqO_q;
   assign mem_dq_oe = memDqOe_q;
   assign nce       = nce_q;
   assign noe       = noe_q;
   assign nwe       = nwe_q;
   assign a_ack     = aAck_q;
   assign b_ack     = bAck_q;
   assign a_rdata   = aRdata_q;
   assign b_rdata   = bRdata_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nvram_access_arb.sv
// Self-checking bench for nvram_access_arb: a default-timing instance shared
// by requesters A/B with random traffic, plus a SETUP=2/PULSE=1/HOLD=3
// instance. Each instance has its own NVRAM model; expectations come from a
// transaction-level memory, round-robin and latency model.
module tb_nvram_access_arb;

`ifdef NVRAM_VERIFY_EN
   localparam bit VFY = 1'b1;
`else
   localparam bit VFY = 1'b0;
`endif
   localparam int SPH   = 1 + 3 + 1;
   localparam int P_SPH = 2 + 1 + 3;

   logic        clk;
   logic        rstN;
   logic        aReq, aWr, aAck, bReq, bWr, bAck;
   logic [12:0] aAddr, bAddr, memAddr;
   logic [7:0]  aWdata, aRdata, bWdata, bRdata, memDqO, memDqI;
   logic        memDqOe, nce, noe, nwe, busy;
   logic        pReq, pWr, pAck, pBAck;
   logic [12:0] pAddr, pMemAddr;
   logic [7:0]  pWdata, pRdata, pBRdata, pMemDqO, pMemDqI;
   logic        pMemDqOe, pNce, pNoe, pNwe, pBusy;
`ifdef NVRAM_VERIFY_EN
   logic        vfyFail, vfyClr, pVfyFail;
`endif

   logic [7:0]  memM [0:8191] = '{default: 8'h00};
   logic [7:0]  memP [0:8191] = '{default: 8'h00};
   logic [7:0]  refMem [int];
   int          vectors = 0;
   int          miscompares = 0;
   bit          lastB = 1'b1;
   logic [7:0]  expA = 8'h00;
   logic [7:0]  expB = 8'h00;

   nvram_access_arb dut (
      .clk_i(clk), .rst_n(rstN),
      .a_req(aReq), .a_wr(aWr), .a_addr(aAddr), .a_wdata(aWdata), .a_ack(aAck), .a_rdata(aRdata),
      .b_req(bReq), .b_wr(bWr), .b_addr(bAddr), .b_wdata(bWdata), .b_ack(bAck), .b_rdata(bRdata),
      .mem_addr(memAddr), .mem_dq_o(memDqO), .mem_dq_oe(memDqOe), .mem_dq_i(memDqI),
      .nce(nce), .noe(noe), .nwe(nwe), .busy(busy)
`ifdef NVRAM_VERIFY_EN
      , .vfy_fail(vfyFail), .vfy_clr(vfyClr)
`endif
   );

   nvram_access_arb #(.SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3)) dutP (
      .clk_i(clk), .rst_n(rstN),
      .a_req(pReq), .a_wr(pWr), .a_addr(pAddr), .a_wdata(pWdata), .a_ack(pAck), .a_rdata(pRdata),
      .b_req(1'b0), .b_wr(1'b0), .b_addr(13'h0000), .b_wdata(8'h00), .b_ack(pBAck), .b_rdata(pBRdata),
      .mem_addr(pMemAddr), .mem_dq_o(pMemDqO), .mem_dq_oe(pMemDqOe), .mem_dq_i(pMemDqI),
      .nce(pNce), .noe(pNoe), .nwe(pNwe), .busy(pBusy)
`ifdef NVRAM_VERIFY_EN
      , .vfy_fail(pVfyFail), .vfy_clr(1'b0)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // NVRAM models: bit 0 of any write to 0x0040 is corrupted in the main one
   assign memDqI  = (!nce && !noe) ? memM[memAddr] : 8'hA9;
   assign pMemDqI = (!pNce && !pNoe) ? memP[pMemAddr] : 8'hA9;
   always @(posedge clk) begin
      if (!nce && !nwe && memDqOe)
         memM[memAddr] <= (memAddr == 13'h0040) ? (memDqO ^ 8'h01) : memDqO;
      if (!pNce && !pNwe && pMemDqOe)
         memP[pMemAddr] <= pMemDqO;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] refRead(input logic [12:0] a);
      return refMem.exists(int'(a)) ? refMem[int'(a)] : 8'h00;
   endfunction

   function automatic int txnLat(input bit w, input int sph);
      return sph + 1 + ((VFY && w) ? sph : 0);
   endfunction

   // Protocol monitors: strobe exclusivity, strobe widths and nce-low length
   int  nweRun = 0, noeRun = 0, nceRun = 0, pNweRun = 0, pNoeRun = 0, pNceRun = 0;
   bit  sawWr = 0, pSawWr = 0;
   always @(negedge clk) begin
      if (!rstN) begin
         nweRun = 0; noeRun = 0; nceRun = 0; sawWr = 0;
         pNweRun = 0; pNoeRun = 0; pNceRun = 0; pSawWr = 0;
      end else begin
         if (!nwe) begin
            checkOutput("nweWithNoe", noe, 1);
            checkOutput("nweWithOe", memDqOe, 1);
            nweRun++;
         end else if (nweRun != 0) begin
            checkOutput("nweWidth", nweRun, 3);
            nweRun = 0;
         end
         if (!noe) noeRun++;
         else if (noeRun != 0) begin
            checkOutput("noeWidth", noeRun, 3);
            noeRun = 0;
         end
         if (!nce) begin
            nceRun++;
            if (!nwe) sawWr = 1;
         end else if (nceRun != 0) begin
            checkOutput("nceLow", nceRun, SPH * ((VFY && sawWr) ? 2 : 1));
            nceRun = 0; sawWr = 0;
         end
         if (!pNwe) begin
            checkOutput("pNweWithNoe", pNoe, 1);
            pNweRun++;
         end else if (pNweRun != 0) begin
            checkOutput("pNweWidth", pNweRun, 1);
            pNweRun = 0;
         end
         if (!pNoe) pNoeRun++;
         else if (pNoeRun != 0) begin
            checkOutput("pNoeWidth", pNoeRun, 1);
            pNoeRun = 0;
         end
         if (!pNce) begin
            pNceRun++;
            if (!pNwe) pSawWr = 1;
         end else if (pNceRun != 0) begin
            checkOutput("pNceLow", pNceRun, P_SPH * ((VFY && pSawWr) ? 2 : 1));
            pNceRun = 0; pSawWr = 0;
         end
      end
   end

   // One round of A and/or B requests raised together; the model decides the
   // service order, latencies and read data before the DUT is driven
   task automatic applyStimulus(input bit useA, input bit useB,
                                input bit aW, input logic [12:0] aAd, input logic [7:0] aD,
                                input bit bW, input logic [12:0] bAd, input logic [7:0] bD);
      bit bFirst;
      int latA, latB, aCyc, bCyc;
      bFirst = useB && (!useA || !lastB);
      latA = txnLat(aW, SPH);
      latB = txnLat(bW, SPH);
      if (useA && useB) begin
         if (bFirst) latA = latB + 1 + latA;
         else        latB = latA + 1 + latB;
      end
      for (int k = 0; k < 2; k++) begin
         if ((k == 0) == bFirst) begin
            if (useB) begin
               if (bW) refMem[int'(bAd)] = bD; else expB = refRead(bAd);
            end
         end else if (useA) begin
            if (aW) refMem[int'(aAd)] = aD; else expA = refRead(aAd);
         end
      end
      lastB = bFirst ? !useA : useB;

      @(negedge clk);
      aReq = useA; aWr = aW; aAddr = aAd; aWdata = aD;
      bReq = useB; bWr = bW; bAddr = bAd; bWdata = bD;
      aCyc = 0; bCyc = 0;
      for (int c = 1; c <= 80 && ((useA && aCyc == 0) || (useB && bCyc == 0)); c++) begin
         @(negedge clk);
         if (aAck) begin
            if (!useA || aCyc != 0) checkOutput("aSpuriousAck", aAck, 0);
            else begin
               aCyc = c; aReq = 1'b0;
               if (!aW) checkOutput("aRdataAtAck", aRdata, expA);
            end
         end
         if (bAck) begin
            if (!useB || bCyc != 0) checkOutput("bSpuriousAck", bAck, 0);
            else begin
               bCyc = c; bReq = 1'b0;
               if (!bW) checkOutput("bRdataAtAck", bRdata, expB);
            end
         end
      end
      aReq = 1'b0; bReq = 1'b0;
      if (useA) checkOutput("aLatency", aCyc, latA);
      if (useB) checkOutput("bLatency", bCyc, latB);
      checkOutput("aRdataHeld", aRdata, expA);
      checkOutput("bRdataHeld", bRdata, expB);
   endtask

   // Single request to the retimed instance with its own latency rule
   task automatic applyParam(input bit w, input logic [12:0] ad, input logic [7:0] d,
                             input logic [7:0] expRd);
      int cyc;
      @(negedge clk);
      pReq = 1'b1; pWr = w; pAddr = ad; pWdata = d;
      cyc = 0;
      for (int c = 1; c <= 80 && cyc == 0; c++) begin
         @(negedge clk);
         if (pAck) begin
            cyc = c; pReq = 1'b0;
            checkOutput("pBusyInDone", pBusy, 1);
            if (!w) checkOutput("pRdata", pRdata, expRd);
         end
      end
      pReq = 1'b0;
      checkOutput("pLatency", cyc, txnLat(w, P_SPH));
      checkOutput("pBAckIdle", pBAck, 0);
      checkOutput("pBRdataIdle", pBRdata, 0);
`ifdef NVRAM_VERIFY_EN
      checkOutput("pVfyFail", pVfyFail, 0);
`endif
   endtask

   initial begin
      logic [12:0] pool [8];
      bit found;
      pool = '{13'h0000, 13'h0100, 13'h0123, 13'h0200, 13'h0555, 13'h0AAA, 13'h1000, 13'h1FFF};
      rstN = 1'b0;
      aReq = 0; aWr = 0; aAddr = '0; aWdata = '0;
      bReq = 0; bWr = 0; bAddr = '0; bWdata = '0;
      pReq = 0; pWr = 0; pAddr = '0; pWdata = '0;
`ifdef NVRAM_VERIFY_EN
      vfyClr = 1'b0;
`endif
      repeat (2) @(negedge clk);
      checkOutput("rstNce", nce, 1);
      checkOutput("rstNoe", noe, 1);
      checkOutput("rstNwe", nwe, 1);
      checkOutput("rstAddr", memAddr, 13'h1FFF);
      checkOutput("rstDqO", memDqO, 0);
      checkOutput("rstDqOe", memDqOe, 0);
      checkOutput("rstAAck", aAck, 0);
      checkOutput("rstBAck", bAck, 0);
      checkOutput("rstARdata", aRdata, 0);
      checkOutput("rstBRdata", bRdata, 0);
      checkOutput("rstBusy", busy, 0);
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("idleBusy", busy, 0);

      $display("[TB] simultaneous pairs from reset");
      applyStimulus(1, 1, 1, 13'h0100, 8'h11, 1, 13'h0200, 8'h22);
      applyStimulus(1, 1, 0, 13'h0200, 8'h00, 0, 13'h0100, 8'h00);
      applyStimulus(1, 1, 1, 13'h0AAA, 8'h33, 0, 13'h0AAA, 8'h00);
      applyStimulus(1, 1, 0, 13'h0100, 8'h00, 1, 13'h0100, 8'h44);

      $display("[TB] directed A write/read");
      applyStimulus(1, 0, 1, 13'h0123, 8'h5A, 0, 13'h0000, 8'h00);
      applyStimulus(1, 0, 0, 13'h0123, 8'h00, 0, 13'h0000, 8'h00);

      $display("[TB] address extremes and held read data");
      applyStimulus(1, 0, 1, 13'h1FFF, 8'hC7, 0, 13'h0000, 8'h00);
      applyStimulus(0, 1, 0, 13'h0000, 8'h00, 1, 13'h0000, 8'h3E);
      applyStimulus(1, 0, 0, 13'h1FFF, 8'h00, 0, 13'h0000, 8'h00);
      applyStimulus(0, 1, 0, 13'h0000, 8'h00, 1, 13'h0000, 8'h81);
      applyStimulus(0, 1, 0, 13'h0000, 8'h00, 1, 13'h1FFF, 8'h18);
      applyStimulus(1, 0, 0, 13'h0000, 8'h00, 0, 13'h0000, 8'h00);

      $display("[TB] random traffic");
      for (int i = 0; i < 30; i++) begin
         int mode;
         mode = int'($urandom_range(0, 2));
         applyStimulus(mode != 1, mode != 0,
                       1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
                       1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom));
      end

`ifdef NVRAM_VERIFY_EN
      $display("[TB] write verify");
      checkOutput("vfyClean", vfyFail, 0);
      applyStimulus(1, 0, 1, 13'h0040, 8'hA5, 0, 13'h0000, 8'h00);
      checkOutput("vfySet", vfyFail, 1);
      @(negedge clk);
      vfyClr = 1'b1;
      @(negedge clk);
      vfyClr = 1'b0;
      checkOutput("vfyCleared", vfyFail, 0);
`endif

      $display("[TB] retimed instance");
      applyParam(1, 13'h0555, 8'hC3, 8'h00);
      applyParam(0, 13'h0555, 8'h00, 8'hC3);
      applyParam(1, 13'h1FFF, 8'h3C, 8'h00);
      applyParam(0, 13'h1FFF, 8'h00, 8'h3C);

      $display("[TB] reset during write strobe");
      @(negedge clk);
      aReq = 1'b1; aWr = 1'b1; aAddr = 13'h1ABC; aWdata = 8'h77;
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (!nwe) found = 1'b1;
      end
      checkOutput("abortNweSeen", found, 1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("abortNwe", nwe, 1);
      checkOutput("abortNce", nce, 1);
      checkOutput("abortNoe", noe, 1);
      checkOutput("abortDqOe", memDqOe, 0);
      checkOutput("abortAddr", memAddr, 13'h1FFF);
      checkOutput("abortBusy", busy, 0);
      aReq = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("abortNoAck", aAck, 0);
      end
      rstN = 1'b1;
      lastB = 1'b1; expA = 8'h00; expB = 8'h00;
      refMem.delete(int'(13'h1ABC));
      checkOutput("abortARdata", aRdata, 0);
      applyStimulus(1, 1, 0, 13'h0123, 8'h00, 0, 13'h0100, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
